// File: rtl/mem_axi_responder.sv
// rtl/mem_axi_responder.sv - AXI4 subordinate backed by an internal 64-bit word RAM
module mem_axi_responder #(
  parameter int unsigned ID_W      = 8,
  parameter int unsigned MEM_AW    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic            inter_soc_clk,
  input  logic            sys_rstn_i,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [ID_W-1:0] s_awid,
  input  logic [31:0]     s_awaddr,
  input  logic [7:0]      s_awlen,
  input  logic [1:0]      s_awburst,
  input  logic            s_wvalid,
  output logic            s_wready,
  input  logic [63:0]     s_wdata,
  input  logic [7:0]      s_wstrb,
  input  logic            s_wlast,
  output logic            s_bvalid,
  input  logic            s_bready,
  output logic [ID_W-1:0] s_bid,
  output logic [1:0]      s_bresp,
  input  logic            s_arvalid,
  output logic            s_arready,
  input  logic [ID_W-1:0] s_arid,
  input  logic [31:0]     s_araddr,
  input  logic [7:0]      s_arlen,
  input  logic [1:0]      s_arburst,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [ID_W-1:0] s_rid,
  output logic [63:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rlast
);

  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + (33'd1 << (MEM_AW + 3));
  localparam logic [MEM_AW-1:0] BASE_IDX = BASE_ADDR[MEM_AW+2:3];

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR_RD, RDATA} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        burst_q, burst_d;
  logic [1:0]        err_q, err_d;
  logic              rr_pref_q, rr_pref_d;   // 1: read wins the next contended grant

  logic [63:0]       mem [DEPTH];
  logic [63:0]       ram_dout;
  logic [MEM_AW-1:0] word_idx;
  logic [31:0]       addr_next;
  logic              in_win;
  logic              bad_burst;
  logic              last_beat;
  logic              grant_wr;
  logic              grant_rd;
  logic              mem_we;
  logic              mem_re;

  // Per-beat address decode; WRAP and the reserved encoding are both refused.
  assign in_win    = ({1'b0, addr_q} >= WIN_LO) && ({1'b0, addr_q} < WIN_HI);
  assign word_idx  = addr_q[MEM_AW+2:3] - BASE_IDX;
  assign bad_burst = burst_q[1];
  assign last_beat = (beat_q == len_q);
  assign addr_next = (burst_q == BURST_INCR) ? addr_q + 32'd8 : addr_q;

  assign s_bid   = id_q;
  assign s_rid   = id_q;
  assign s_bresp = (state_q == WRESP) ? err_q : RESP_OKAY;
  assign s_rlast = (state_q == RDATA) && last_beat;
  assign s_rdata = ((state_q == RDATA) && in_win && !bad_burst) ? ram_dout : 64'd0;
  assign s_rresp = (state_q != RDATA) ? RESP_OKAY :
                   !in_win            ? RESP_DECERR :
                   bad_burst          ? RESP_SLVERR : RESP_OKAY;

  // Next-state, handshake outputs and RAM strobes for the single-transaction FSM.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    err_d     = err_q;
    rr_pref_d = rr_pref_q;
    s_awready = 1'b0;
    s_arready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_rvalid  = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_awvalid && s_arvalid) begin
          grant_rd  = rr_pref_q;
          grant_wr  = !rr_pref_q;
          rr_pref_d = !rr_pref_q;
        end else begin
          grant_wr = s_awvalid;
          grant_rd = s_arvalid;
        end
        if (grant_wr) begin
          s_awready = 1'b1;
          id_d      = s_awid;
          addr_d    = s_awaddr;
          len_d     = s_awlen;
          burst_d   = s_awburst;
          beat_d    = 8'd0;
          err_d     = RESP_OKAY;
          state_d   = WDATA;
        end else if (grant_rd) begin
          s_arready = 1'b1;
          id_d      = s_arid;
          addr_d    = s_araddr;
          len_d     = s_arlen;
          burst_d   = s_arburst;
          beat_d    = 8'd0;
          err_d     = RESP_OKAY;
          state_d   = RADDR_RD;
        end
      end
      WDATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          mem_we = in_win && !bad_burst;
          if (!in_win) begin
            err_d = RESP_DECERR;
          end else if (bad_burst && (err_q != RESP_DECERR)) begin
            err_d = RESP_SLVERR;
          end
          if ((s_wlast != last_beat) && (err_d != RESP_DECERR)) begin
            err_d = RESP_SLVERR;
          end
          if (last_beat) begin
            state_d = WRESP;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_next;
          end
        end
      end
      WRESP: begin
        s_bvalid = 1'b1;
        if (s_bready) begin
          state_d = IDLE;
        end
      end
      RADDR_RD: begin
        mem_re  = 1'b1;
        state_d = RDATA;
      end
      RDATA: begin
        s_rvalid = 1'b1;
        if (s_rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_next;
            state_d = RADDR_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and transaction context registers.
  always_ff @(posedge inter_soc_clk or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      err_q     <= RESP_OKAY;
      rr_pref_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      rr_pref_q <= rr_pref_d;
    end
  end

  // Byte-masked write port and registered read port; contents survive reset.
  always_ff @(posedge inter_soc_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (s_wstrb[b]) begin
          mem[word_idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
        end
      end
    end
    if (mem_re) begin
      ram_dout <= mem[word_idx];
    end
  end

endmodule

// File: tb/tb_mem_axi_responder.sv
// tb/tb_mem_axi_responder.sv - scoreboard bench for mem_axi_responder
module tb_mem_axi_responder;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_awvalid, s_awready;
  logic [7:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [1:0]  s_awburst;
  logic        s_wvalid, s_wready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [7:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [7:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [7:0]  s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;

  typedef struct {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t exp_r[$];
  b_exp_t exp_b[$];
  bit     exp_grant[$];   // 1 = read grant, 0 = write grant

  int n_checks = 0;
  int n_fail   = 0;
  int rmode    = 0;       // 0: rready high, 1: toggling, 2: held low

  logic [63:0] wb_data [16];
  logic [7:0]  wb_strb [16];
  logic        wb_last [16];

  mem_axi_responder dut (
    .inter_soc_clk(clk), .sys_rstn_i(rstn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout got no handshake expected handshake", name);
  endtask

  task automatic push_r(input logic [7:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    exp_r.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
  endtask

  task automatic set_wb(input int i, input logic [63:0] d, input logic [7:0] s, input logic l);
    wb_data[i] = d; wb_strb[i] = s; wb_last[i] = l;
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t;
    @(posedge clk); #1;
    s_awvalid = 1'b1; s_awid = id; s_awaddr = addr; s_awlen = len; s_awburst = burst;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_awready && t < 300);
    if (!s_awready) timeout_fail("aw_handshake");
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_wvalid = 1'b1; s_wdata = wb_data[i]; s_wstrb = wb_strb[i]; s_wlast = wb_last[i];
      t = 0;
      do begin @(negedge clk); t++; end while (!s_wready && t < 300);
      if (!s_wready) timeout_fail("w_handshake");
      @(posedge clk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t;
    @(posedge clk); #1;
    s_arvalid = 1'b1; s_arid = id; s_araddr = addr; s_arlen = len; s_arburst = burst;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_arready && t < 300);
    if (!s_arready) timeout_fail("ar_handshake");
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0 || exp_grant.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_r.size() != 0 || exp_b.size() != 0 || exp_grant.size() != 0) timeout_fail("drain");
    exp_r.delete(); exp_b.delete(); exp_grant.delete();
  endtask

  // rready pattern generator
  initial begin
    s_rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1:       s_rready = ~s_rready;
        2:       s_rready = 1'b0;
        default: s_rready = 1'b1;
      endcase
    end
  end

  // Monitor: pops expectations on each observed handshake, checks stall stability.
  initial begin
    logic        stall_prev;
    logic [74:0] held;
    r_exp_t      er;
    b_exp_t      eb;
    bit          g;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (s_awvalid && s_awready) begin
        if (exp_grant.size() == 0) timeout_fail("grant_unexpected_w");
        else begin g = exp_grant.pop_front(); chk("grant_order_w", {79'd0, 1'b0}, {79'd0, g}); end
      end
      if (s_arvalid && s_arready) begin
        if (exp_grant.size() == 0) timeout_fail("grant_unexpected_r");
        else begin g = exp_grant.pop_front(); chk("grant_order_r", {79'd0, 1'b1}, {79'd0, g}); end
      end
      if (s_bvalid && s_bready) begin
        if (exp_b.size() == 0) timeout_fail("b_unexpected");
        else begin
          eb = exp_b.pop_front();
          chk("b_id_resp", {70'd0, s_bid, s_bresp}, {70'd0, eb.id, eb.resp});
        end
      end
      if (stall_prev && s_rvalid) begin
        chk("r_stall_stable", {5'd0, s_rid, s_rdata, s_rresp, s_rlast}, {5'd0, held});
      end
      if (s_rvalid && s_rready) begin
        if (exp_r.size() == 0) timeout_fail("r_unexpected");
        else begin
          er = exp_r.pop_front();
          chk("r_data", {16'd0, s_rdata}, {16'd0, er.data});
          chk("r_id_resp_last", {69'd0, s_rid, s_rresp, s_rlast}, {69'd0, er.id, er.resp, er.last});
        end
      end
      stall_prev = s_rvalid && !s_rready;
      held = {s_rid, s_rdata, s_rresp, s_rlast};
    end
  end

  // Directed stimulus
  initial begin
    int t;
    rstn = 1'b0;
    s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awburst = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arburst = 0;
    s_bready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast, s_bresp, s_rresp, s_bid, s_rid, s_rdata},
        80'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Contention pair 1 after reset: read wins, then the write.
    exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
    push_r(8'h11, 64'd0, DECERR, 1'b1);
    push_b(8'h21, OKAY);
    set_wb(0, 64'hAAAA_0001_0000_0100, 8'hFF, 1'b1);
    fork
      do_write(8'h21, 32'h8000_0100, 8'd0, INCR);
      do_read(8'h11, 32'h0000_0000, 8'd0, INCR);
    join
    wait_idle();

    // Contention pair 2: preference has flipped to write.
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    push_b(8'h22, OKAY);
    push_r(8'h12, 64'hAAAA_0001_0000_0100, OKAY, 1'b1);
    set_wb(0, 64'hBBBB_0002_0000_0108, 8'hFF, 1'b1);
    fork
      do_write(8'h22, 32'h8000_0108, 8'd0, INCR);
      do_read(8'h12, 32'h8000_0100, 8'd0, INCR);
    join
    wait_idle();

    // Single-beat write then read back.
    exp_grant.push_back(1'b0); push_b(8'h5A, OKAY);
    set_wb(0, 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    do_write(8'h5A, 32'h8000_0010, 8'd0, INCR);
    exp_grant.push_back(1'b1); push_r(8'h3C, 64'h1122_3344_5566_7788, OKAY, 1'b1);
    do_read(8'h3C, 32'h8000_0010, 8'd0, INCR);
    wait_idle();

    // Partial strobe merge.
    exp_grant.push_back(1'b0); push_b(8'h01, OKAY);
    set_wb(0, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b1);
    do_write(8'h01, 32'h8000_0010, 8'd0, INCR);
    exp_grant.push_back(1'b1); push_r(8'h02, 64'h1122_3344_AAAA_AAAA, OKAY, 1'b1);
    do_read(8'h02, 32'h8000_0010, 8'd0, INCR);
    wait_idle();

    // Fill words 0..3, then INCR read burst with rready toggling.
    exp_grant.push_back(1'b0); push_b(8'h03, OKAY);
    set_wb(0, 64'hD000_0000_0000_0000, 8'hFF, 1'b0);
    set_wb(1, 64'hD111_0000_0000_0001, 8'hFF, 1'b0);
    set_wb(2, 64'hD222_0000_0000_0002, 8'hFF, 1'b0);
    set_wb(3, 64'hD333_0000_0000_0003, 8'hFF, 1'b1);
    do_write(8'h03, 32'h8000_0000, 8'd3, INCR);
    wait_idle();
    rmode = 1;
    exp_grant.push_back(1'b1);
    push_r(8'h44, 64'hD000_0000_0000_0000, OKAY, 1'b0);
    push_r(8'h44, 64'hD111_0000_0000_0001, OKAY, 1'b0);
    push_r(8'h44, 64'hD222_0000_0000_0002, OKAY, 1'b0);
    push_r(8'h44, 64'hD333_0000_0000_0003, OKAY, 1'b1);
    do_read(8'h44, 32'h8000_0000, 8'd3, INCR);
    wait_idle();
    rmode = 0;

    // Out-of-window write: DECERR and RAM untouched.
    exp_grant.push_back(1'b0); push_b(8'h05, DECERR);
    set_wb(0, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 1'b0);
    set_wb(1, 64'hBEEF_BEEF_BEEF_BEEF, 8'hFF, 1'b1);
    do_write(8'h05, 32'h1000_0000, 8'd1, INCR);
    exp_grant.push_back(1'b1);
    push_r(8'h06, 64'hD000_0000_0000_0000, OKAY, 1'b0);
    push_r(8'h06, 64'hD111_0000_0000_0001, OKAY, 1'b1);
    do_read(8'h06, 32'h8000_0000, 8'd1, INCR);
    wait_idle();

    // WRAP read: zero data, SLVERR each beat.
    exp_grant.push_back(1'b1);
    push_r(8'h07, 64'd0, SLVERR, 1'b0);
    push_r(8'h07, 64'd0, SLVERR, 1'b1);
    do_read(8'h07, 32'h8000_0000, 8'd1, WRAP);
    wait_idle();

    // Early wlast: all 3 beats accepted, SLVERR.
    exp_grant.push_back(1'b0); push_b(8'h08, SLVERR);
    set_wb(0, 64'h0000_0000_0000_0040, 8'hFF, 1'b1);
    set_wb(1, 64'h0000_0000_0000_0048, 8'hFF, 1'b0);
    set_wb(2, 64'h0000_0000_0000_0050, 8'hFF, 1'b0);
    do_write(8'h08, 32'h8000_0040, 8'd2, INCR);
    wait_idle();

    // FIXED write keeps the address: last beat wins; FIXED read repeats it.
    exp_grant.push_back(1'b0); push_b(8'h09, OKAY);
    set_wb(0, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 1'b0);
    set_wb(1, 64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1);
    do_write(8'h09, 32'h8000_0080, 8'd1, FIXED);
    exp_grant.push_back(1'b1);
    push_r(8'h0A, 64'h1234_5678_9ABC_DEF0, OKAY, 1'b0);
    push_r(8'h0A, 64'h1234_5678_9ABC_DEF0, OKAY, 1'b1);
    do_read(8'h0A, 32'h8000_0080, 8'd1, FIXED);
    wait_idle();

    // Reset while a read beat is stalled in RDATA.
    rmode = 2;
    exp_grant.push_back(1'b1);
    do_read(8'h0B, 32'h8000_0000, 8'd3, INCR);
    t = 0;
    while (!s_rvalid && t < 50) begin @(negedge clk); t++; end
    if (!s_rvalid) timeout_fail("rvalid_before_reset");
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("async_reset_rvalid", {79'd0, s_rvalid}, 80'd0);
    chk("async_reset_outputs", {s_bvalid, s_rlast, s_rresp, s_rid, s_rdata}, 80'd0);
    @(posedge clk); #1 rstn = 1'b1;
    rmode = 0;
    wait_idle();

    // Normal transaction after reset; RAM content preserved.
    exp_grant.push_back(1'b1); push_r(8'h0C, 64'hD333_0000_0000_0003, OKAY, 1'b1);
    do_read(8'h0C, 32'h8000_0018, 8'd0, INCR);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_axi_responder.md
Name: mem_axi_responder

Overview:
AXI4 subordinate that terminates the core's 64-bit memory bus (mem_core_*) on FPGA, backed by an internal word-addressed RAM. It services one transaction at a time, supports INCR and FIXED bursts up to 256 beats, and applies byte-strobe masking on writes. Out-of-window and malformed requests get error responses, so the core always sees a completed transaction.

Parameters:
ID_W, 8, width of AWID/ARID/BID/RID
MEM_AW, 16, RAM word-address bits; depth 2^MEM_AW x 64b (512 KiB default)
BASE_ADDR, 32'h8000_0000, byte address of RAM word 0

Ports:
inter_soc_clk  in  1  sole clock
sys_rstn_i  in  1  asynchronous active-low reset
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_awid  in  ID_W  write ID
s_awaddr  in  32  write byte address
s_awlen  in  8  beats-1
s_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_wdata  in  64  write data
s_wstrb  in  8  byte enables
s_wlast  in  1  last write beat
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_bid  out  ID_W  echoed AWID
s_bresp  out  2  write response
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_arid  in  ID_W  read ID
s_araddr  in  32  read byte address
s_arlen  in  8  beats-1
s_arburst  in  2  burst type
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_rid  out  ID_W  echoed ARID
s_rdata  out  64  read data
s_rresp  out  2  read response
s_rlast  out  1  last read beat

Behaviour:
- Reset (async assert, sync deassert edge irrelevant): FSM=IDLE, all ready/valid outputs 0, bid/rid/bresp/rresp/rdata/rlast 0, rr_pref=READ. RAM contents not reset.
- Transfers are fixed at 8 bytes; addr[2:0] ignored. Word index = (addr-BASE_ADDR)>>3. In-window iff BASE_ADDR <= addr < BASE_ADDR + 2^(MEM_AW+3), checked per beat.
- FSM states: IDLE, WDATA, WRESP, RADDR_RD, RDATA.
- IDLE: s_awready = s_arready = 0 until a grant is made. If only AW valid, grant write; if only AR valid, grant read. If both are valid, grant rr_pref, then toggle rr_pref. Grant cycle: assert the chosen *ready for exactly 1 cycle, latch id/addr/len/burst, clear the beat counter and err flag. Write goes to WDATA; read goes to RADDR_RD.
- WDATA: s_wready=1. On each w handshake: if in-window and burst!=WRAP, write RAM bytes where wstrb=1. Error conditions: burst==WRAP, or any out-of-window beat, sets err (DECERR 2'b11 for window, SLVERR 2'b10 for WRAP; DECERR wins). If wlast != (beat==len), set SLVERR unless DECERR is already set. Termination is by count only: after len+1 beats go to WRESP; extra wlast is ignored.
- Address step: INCR adds 8 per beat; FIXED holds the address. 32-bit wrap-around is permitted and lands out-of-window (DECERR).
- WRESP: s_bvalid=1, bid=latched id, bresp=OKAY/err. Hold stable until s_bready, then go to IDLE. bvalid never precedes the last w handshake.
- RADDR_RD: issue the RAM read (1-cycle synchronous RAM), then go to RDATA.
- RDATA: s_rvalid=1. rdata = RAM word, or 0 if out-of-window or WRAP. rresp is per beat: OKAY, DECERR, or SLVERR (WRAP). rlast=(beat==len). rid=latched id. Outputs are held stable while rvalid && !rready. On handshake: if last, go to IDLE; else step the address and go to RADDR_RD. Throughput is 1 beat per 2 cycles.
- Read-after-write to the same word returns the new data, because transactions are serialized.
- Mid-operation reset: return immediately to the reset state. The partial write burst stays in the RAM; no response is issued.

Test Plan:
- Write awaddr=0x8000_0010, awlen=0, INCR, wdata=0x1122334455667788, wstrb=0xFF; then read the same address -> bresp=00, bid echoed; rdata=0x1122334455667788, rresp=00, rlast=1.
- Partial strobe write wstrb=0x0F, wdata=all 0xAA over an existing word 0x1122334455667788 -> subsequent read returns 0x11223344AAAAAAAA.
- INCR read burst arlen=3 at 0x8000_0000 with rready toggling 1/0 -> 4 beats of consecutive words, rlast only on beat 4, rdata/rid stable during stalls.
- awvalid and arvalid asserted in the same cycle, twice, right after reset -> first grant is read, second is write; no lost or duplicated transaction.
- Write to 0x1000_0000 with awlen=1 -> both w beats accepted, RAM unchanged, bresp=11. WRAP read arlen=1 -> 2 beats, rdata=0, rresp=10.
- wlast asserted on beat 0 of an awlen=2 burst -> 3 beats accepted, bresp=10. Assert sys_rstn_i low during RDATA -> rvalid drops to 0 asynchronously, FSM returns to IDLE, the next transaction completes normally.
